axi_lite_reg_bank: RTL and testbench
====================================

Name: axi_lite_reg_bank

Overview:
Parametrised AXI4-Lite slave register bank. It replaces the fixed two-register control/version template with the following:
- N read/write control registers, byte-strobe aware.
- M read-only status inputs.
- Edge-triggered interrupt status/enable pair with write-1-to-clear and an interrupt output.

It sits between the AXI-Lite interconnect and user logic as the standard register front-end for peripheral cores. It implements its own AW/W/B and AR/R handshakes with no helper submodule.

Parameters:
ADDR_WIDTH, 32, AXI address width (at least 8).
NUM_CTRL, 4, number of RW control registers (1..64).
NUM_STATUS, 2, number of RO status registers (1..64).
NUM_IRQ, 8, number of interrupt sources (1..32).
CTRL_RESET, 32'h0, reset value of every control register.
MAJOR_VERSION, 1, version field [31:28].
MINOR_VERSION, 1, version field [27:20].
REVISION, 0, version field [19:16]. Bits [15:0] read 0.

Ports:
i_axi_clk  in  1  sole clock.
i_axi_rst  in  1  asynchronous, active-low reset.
i_awvalid  in  1  write address valid.
i_awaddr  in  ADDR_WIDTH  write byte address.
o_awready  out  1  write address ready.
i_wvalid  in  1  write data valid.
o_wready  out  1  write data ready.
i_wstrb  in  4  byte strobes.
i_wdata  in  32  write data.
o_bvalid  out  1  write response valid.
i_bready  in  1  write response ready.
o_bresp  out  2  00 OKAY, 10 SLVERR.
i_arvalid  in  1  read address valid.
o_arready  out  1  read address ready.
i_araddr  in  ADDR_WIDTH  read byte address.
o_rvalid  out  1  read data valid.
i_rready  in  1  read data ready.
o_rresp  out  2  00 OKAY, 10 SLVERR.
o_rdata  out  32  read data.
o_ctrl  out  32*NUM_CTRL  flattened control registers; reg k is at [32k+31:32k].
i_status  in  32*NUM_STATUS  flattened status words, sampled at read.
i_irq_src  in  NUM_IRQ  interrupt sources; a rising edge latches the source.
o_irq  out  1  OR of (irq_status & irq_enable).

Behaviour:
Address map. Word index = addr[ADDR_WIDTH-1:2]; addr[1:0] are ignored.
- 0: VERSION, RO.
- 1: IRQ_STATUS, W1C.
- 2: IRQ_ENABLE, RW; bits at or above NUM_IRQ read 0.
- 3: reserved; invalid.
- 4 .. 4+NUM_CTRL-1: CTRL, RW.
- 4+NUM_CTRL .. 4+NUM_CTRL+NUM_STATUS-1: STATUS, RO.
- All other indices are invalid.

Reset (i_axi_rst=0, asynchronous):
- o_awready=0, o_wready=0, o_bvalid=0, o_bresp=0, o_arready=0, o_rvalid=0, o_rresp=0, o_rdata=0.
- All CTRL=CTRL_RESET; IRQ_STATUS=0, IRQ_ENABLE=0, o_irq=0, edge-detect history=0.
- Ready outputs rise on the first clock edge after reset deasserts.

Write FSM, states W_IDLE and W_RESP:
- W_IDLE: o_awready=1 until AW is captured; o_wready=1 until W is captured. AW and W are captured independently, in either order or in the same cycle.
- In the cycle both are held, the write is performed and the FSM moves to W_RESP. o_bvalid=1 on the next edge.
- Latency: AW and W accepted together at edge n gives o_bvalid=1 after edge n+1.
- W_RESP: o_awready=0, o_wready=0. o_bvalid and o_bresp are held until i_bready=1, then the FSM returns to W_IDLE. With i_bready already high, the next AW/W can be accepted 1 cycle after the B handshake.

Write semantics:
- RW registers: byte lane b is updated only when i_wstrb[b]=1.
- IRQ_STATUS: a status bit clears where wdata=1 and its lane strobe=1.
- A write to an RO, reserved or invalid address has no effect and returns bresp=SLVERR. All other writes return OKAY, including wstrb=0, which writes nothing.

Read FSM, states R_IDLE and R_RESP:
- R_IDLE: o_arready=1. AR accepted at edge n gives o_rvalid=1 with registered o_rdata/o_rresp after edge n.
- R_RESP: o_arready=0. Data is held stable until i_rready=1, then the FSM returns to R_IDLE.
- Invalid or reserved address: rdata=0, rresp=SLVERR.
- STATUS words are sampled at the AR accept edge.

Concurrency:
- Read and write FSMs are independent.
- A same-cycle read and write to one register returns the pre-write value.

Interrupts:
- Edge detect: src & ~src_q, with src_q registered every cycle.
- A detected edge sets its IRQ_STATUS bit. An edge and a W1C to the same bit in the same cycle leaves the bit set (set wins).
- o_irq is registered: it is high 1 cycle after (status & enable) becomes nonzero.
- A level held high does not re-set a bit after it is cleared.

Reset mid-transaction: any in-flight AW/W/AR is dropped and no response is issued.

Test Plan:
- Reset, then read addr 0x00 -> rdata=0x1010_0000, rresp=00; reset values confirmed on all outputs.
- Write 0xDEADBEEF to 0x10 (wstrb=F), then write 0x000000AA with wstrb=1 -> o_ctrl[31:0]=0xDEADBEAA; read-back matches; bresp=00. Repeat with W issued 3 cycles before AW -> same result, with bvalid 1 cycle after the second capture.
- Write 0x12345678 to 0x00 and to 0x0C; read 0x40 with NUM_CTRL=4 and NUM_STATUS=2 -> bresp=10 on both writes, VERSION unchanged; read returns rdata=0, rresp=10.
- Drive i_irq_src[3] 0->1 with IRQ_ENABLE=0x08 -> IRQ_STATUS=0x08 and o_irq=1. Write 0x08 to 0x04 -> status=0, o_irq=0 next cycle. Pulse an edge in the W1C cycle -> bit stays 1.
- Hold i_bready=0 and i_rready=0 for 5 cycles -> bvalid/rvalid and their data stay stable; awready=wready=arready=0 throughout. Release -> the handshakes complete.
- Assert i_axi_rst low mid-write, after AW is captured and before W -> no bvalid issued. CTRL returns to CTRL_RESET immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/axi_lite_reg_bank_if.sv
// AXI4-Lite slave-side bus bundle for the register bank: AW/W/B write channels and AR/R read channels.
interface axi_lite_reg_bank_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  i_awvalid;
    logic [ADDR_WIDTH-1:0] i_awaddr;
    logic                  o_awready;
    logic                  i_wvalid;
    logic                  o_wready;
    logic [3:0]            i_wstrb;
    logic [31:0]           i_wdata;
    logic                  o_bvalid;
    logic                  i_bready;
    logic [1:0]            o_bresp;
    logic                  i_arvalid;
    logic                  o_arready;
    logic [ADDR_WIDTH-1:0] i_araddr;
    logic                  o_rvalid;
    logic                  i_rready;
    logic [1:0]            o_rresp;
    logic [31:0]           o_rdata;

    modport slave (
        input  i_awvalid, i_awaddr, i_wvalid, i_wstrb, i_wdata, i_bready,
        input  i_arvalid, i_araddr, i_rready,
        output o_awready, o_wready, o_bvalid, o_bresp,
        output o_arready, o_rvalid, o_rresp, o_rdata
    );

    modport master (
        output i_awvalid, i_awaddr, i_wvalid, i_wstrb, i_wdata, i_bready,
        output i_arvalid, i_araddr, i_rready,
        input  o_awready, o_wready, o_bvalid, o_bresp,
        input  o_arready, o_rvalid, o_rresp, o_rdata
    );
endinterface

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite register bank: VERSION, W1C interrupt status, interrupt enable,
// NUM_CTRL byte-strobed control words and NUM_STATUS read-only status words.
module axi_lite_reg_bank #(
    parameter int          ADDR_WIDTH    = 32,
    parameter int          NUM_CTRL      = 4,
    parameter int          NUM_STATUS    = 2,
    parameter int          NUM_IRQ       = 8,
    parameter logic [31:0] CTRL_RESET    = 32'h0,
    parameter int          MAJOR_VERSION = 1,
    parameter int          MINOR_VERSION = 1,
    parameter int          REVISION      = 0
) (
    input  logic                    i_axi_clk,
    input  logic                    i_axi_rst,
    axi_lite_reg_bank_if.slave      bus,
    output logic [32*NUM_CTRL-1:0]  o_ctrl,
    input  logic [32*NUM_STATUS-1:0] i_status,
    input  logic [NUM_IRQ-1:0]      i_irq_src,
    output logic                    o_irq
);
    localparam int          IW          = ADDR_WIDTH - 2;
    localparam int          CTRL_BASE   = 4;
    localparam int          STATUS_BASE = CTRL_BASE + NUM_CTRL;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] VERSION     = {4'(MAJOR_VERSION), 8'(MINOR_VERSION),
                                           4'(REVISION), 16'h0000};

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{strb[b]}};
        return m;
    endfunction

    w_state_t          w_state, w_state_nx;
    r_state_t          r_state, r_state_nx;
    logic              ready_en;
    logic              aw_held, w_held;
    logic [IW-1:0]     awaddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q;
    logic [31:0]       rdata_q;
    logic [1:0]        rresp_q;
    logic [31:0]       ctrl_q [NUM_CTRL];
    logic [NUM_IRQ-1:0] irq_en_q, irq_stat_q, irq_src_q, irq_edge, irq_clr;
    logic              irq_q;

    logic              awready_c, wready_c, bvalid_c, arready_c, rvalid_c;
    logic              aw_fire, w_fire, ar_fire, do_write;
    logic [31:0]       wmask;
    logic              wr_err, wr_hit_stat, wr_hit_en;
    logic [NUM_CTRL-1:0] wr_hit_ctrl;
    logic [IW-1:0]     ar_idx;
    logic [31:0]       rd_word, irq_stat_rd, irq_en_rd;
    logic              rd_err;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{bus.i_awaddr[1:0], bus.i_araddr[1:0]};

    assign aw_fire  = bus.i_awvalid & awready_c;
    assign w_fire   = bus.i_wvalid & wready_c;
    assign ar_fire  = bus.i_arvalid & arready_c;
    assign do_write = (w_state == W_IDLE) & aw_held & w_held;
    assign wmask    = lane_mask(wstrb_q);
    assign irq_edge = i_irq_src & ~irq_src_q;
    assign irq_clr  = (do_write && wr_hit_stat) ? (wdata_q[NUM_IRQ-1:0] & wmask[NUM_IRQ-1:0])
                                                : '0;

    assign bus.o_awready = awready_c;
    assign bus.o_wready  = wready_c;
    assign bus.o_bvalid  = bvalid_c;
    assign bus.o_bresp   = bresp_q;
    assign bus.o_arready = arready_c;
    assign bus.o_rvalid  = rvalid_c;
    assign bus.o_rresp   = rresp_q;
    assign bus.o_rdata   = rdata_q;
    assign o_irq         = irq_q;

    for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl_out
        assign o_ctrl[32*k +: 32] = ctrl_q[k];
    end

    // Readies stay low until the first clock edge after reset is released.
    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            ready_en <= 1'b0;
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
        end else begin
            ready_en <= 1'b1;
            w_state  <= w_state_nx;
            r_state  <= r_state_nx;
        end
    end

    always_comb begin
        w_state_nx = w_state;
        awready_c  = 1'b0;
        wready_c   = 1'b0;
        bvalid_c   = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready_c = ready_en & ~aw_held;
                wready_c  = ready_en & ~w_held;
                if (aw_held && w_held) w_state_nx = W_RESP;
            end
            W_RESP: begin
                bvalid_c = 1'b1;
                if (bus.i_bready) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_nx = r_state;
        arready_c  = 1'b0;
        rvalid_c   = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready_c = ready_en;
                if (ar_fire) r_state_nx = R_RESP;
            end
            R_RESP: begin
                rvalid_c = 1'b1;
                if (bus.i_rready) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_comb begin
        wr_err      = 1'b1;
        wr_hit_stat = 1'b0;
        wr_hit_en   = 1'b0;
        wr_hit_ctrl = '0;
        if (awaddr_q == IW'(1)) begin
            wr_hit_stat = 1'b1;
            wr_err      = 1'b0;
        end
        if (awaddr_q == IW'(2)) begin
            wr_hit_en = 1'b1;
            wr_err    = 1'b0;
        end
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (awaddr_q == IW'(CTRL_BASE + k)) begin
                wr_hit_ctrl[k] = 1'b1;
                wr_err         = 1'b0;
            end
        end
    end

    // Read mux; anything not matched falls through as SLVERR with zero data.
    always_comb begin
        ar_idx      = bus.i_araddr[ADDR_WIDTH-1:2];
        irq_stat_rd = '0;
        irq_en_rd   = '0;
        irq_stat_rd[NUM_IRQ-1:0] = irq_stat_q;
        irq_en_rd[NUM_IRQ-1:0]   = irq_en_q;
        rd_word = '0;
        rd_err  = 1'b1;
        if (ar_idx == IW'(0)) begin
            rd_word = VERSION;
            rd_err  = 1'b0;
        end
        if (ar_idx == IW'(1)) begin
            rd_word = irq_stat_rd;
            rd_err  = 1'b0;
        end
        if (ar_idx == IW'(2)) begin
            rd_word = irq_en_rd;
            rd_err  = 1'b0;
        end
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (ar_idx == IW'(CTRL_BASE + k)) begin
                rd_word = ctrl_q[k];
                rd_err  = 1'b0;
            end
        end
        for (int k = 0; k < NUM_STATUS; k++) begin
            if (ar_idx == IW'(STATUS_BASE + k)) begin
                rd_word = i_status[32*k +: 32];
                rd_err  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (aw_fire) begin
                aw_held  <= 1'b1;
                awaddr_q <= bus.i_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_fire) begin
                w_held  <= 1'b1;
                wdata_q <= bus.i_wdata;
                wstrb_q <= bus.i_wstrb;
            end
            if (do_write) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (ar_fire) begin
                rdata_q <= rd_word;
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // A fresh edge on a source overrides a simultaneous W1C of the same bit.
    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            for (int k = 0; k < NUM_CTRL; k++) ctrl_q[k] <= CTRL_RESET;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            irq_src_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (do_write && wr_hit_ctrl[k])
                    ctrl_q[k] <= (ctrl_q[k] & ~wmask) | (wdata_q & wmask);
            end
            if (do_write && wr_hit_en)
                irq_en_q <= (irq_en_q & ~wmask[NUM_IRQ-1:0]) |
                            (wdata_q[NUM_IRQ-1:0] & wmask[NUM_IRQ-1:0]);
            irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_edge;
            irq_src_q  <= i_irq_src;
            irq_q      <= |(irq_stat_q & irq_en_q);
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Directed bench for axi_lite_reg_bank with default parameters (4 CTRL, 2 STATUS, 8 IRQ).
module tb_axi_lite_reg_bank;
    logic         clk;
    logic         rst_n;
    logic [127:0] ctrl;
    logic [63:0]  status;
    logic [7:0]   irq_src;
    logic         irq;
    int           checks;
    int           failures;

    axi_lite_reg_bank_if #(.ADDR_WIDTH(32)) bus ();

    axi_lite_reg_bank dut (
        .i_axi_clk (clk),
        .i_axi_rst (rst_n),
        .bus       (bus),
        .o_ctrl    (ctrl),
        .i_status  (status),
        .i_irq_src (irq_src),
        .o_irq     (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
        int  n;
        logic aw_acc, w_acc;
        @(negedge clk);
        bus.i_awaddr  = a;
        bus.i_awvalid = 1'b1;
        bus.i_wdata   = d;
        bus.i_wstrb   = s;
        bus.i_wvalid  = 1'b1;
        n = 0;
        while ((bus.i_awvalid || bus.i_wvalid) && n < 20) begin
            aw_acc = bus.i_awvalid & bus.o_awready;
            w_acc  = bus.i_wvalid & bus.o_wready;
            @(negedge clk);
            if (aw_acc) bus.i_awvalid = 1'b0;
            if (w_acc)  bus.i_wvalid  = 1'b0;
            n++;
        end
        bus.i_awvalid = 1'b0;
        bus.i_wvalid  = 1'b0;
        n = 0;
        while (!bus.o_bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_bvalid) begin
            checks++;
            failures++;
            $display("FAIL write_timeout addr=%h: bvalid=%b required 1", a, bus.o_bvalid);
            resp = 2'b11;
        end else begin
            resp = bus.o_bresp;
        end
        @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.i_araddr  = a;
        bus.i_arvalid = 1'b1;
        n = 0;
        while (!bus.o_arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.i_arvalid = 1'b0;
        n = 0;
        while (!bus.o_rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_rvalid) begin
            checks++;
            failures++;
            $display("FAIL read_timeout addr=%h: rvalid=%b required 1", a, bus.o_rvalid);
            d    = 32'hFFFF_FFFF;
            resp = 2'b11;
        end else begin
            d    = bus.o_rdata;
            resp = bus.o_rresp;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.o_awready, bus.o_wready, bus.o_arready, bus.o_bvalid, bus.o_rvalid,
             bus.o_bresp, bus.o_rresp, irq} !== 10'b0)
            begin failures++; $display("FAIL reset_ctrl_outputs: got %b required 0",
                {bus.o_awready, bus.o_wready, bus.o_arready, bus.o_bvalid, bus.o_rvalid,
                 bus.o_bresp, bus.o_rresp, irq}); end
        checks++;
        if (bus.o_rdata !== 32'h0 || ctrl !== 128'h0)
            begin failures++; $display("FAIL reset_data: rdata=%h ctrl=%h required 0", bus.o_rdata, ctrl); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.o_awready !== 1'b0)
            begin failures++; $display("FAIL ready_before_edge: awready=%b required 0", bus.o_awready); end
        @(negedge clk);
        checks++;
        if ({bus.o_awready, bus.o_wready, bus.o_arready} !== 3'b111)
            begin failures++; $display("FAIL ready_after_edge: got %b required 111",
                {bus.o_awready, bus.o_wready, bus.o_arready}); end
        do_read(32'h00, d, r);
        checks++;
        if (d !== 32'h1010_0000 || r !== 2'b00)
            begin failures++; $display("FAIL version_read: got %h/%b required 10100000/00", d, r); end
    endtask

    task automatic test_ctrl_write();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(32'h10, 32'hDEAD_BEEF, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin failures++; $display("FAIL ctrl0_bresp1: got %b required 00", r); end
        do_write(32'h10, 32'h0000_00AA, 4'h1, r);
        checks++;
        if (r !== 2'b00) begin failures++; $display("FAIL ctrl0_bresp2: got %b required 00", r); end
        checks++;
        if (ctrl[31:0] !== 32'hDEAD_BEAA)
            begin failures++; $display("FAIL ctrl0_port: got %h required deadbeaa", ctrl[31:0]); end
        do_read(32'h10, d, r);
        checks++;
        if (d !== 32'hDEAD_BEAA || r !== 2'b00)
            begin failures++; $display("FAIL ctrl0_readback: got %h/%b required deadbeaa/00", d, r); end
    endtask

    task automatic write_w_first(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int lat;
        @(negedge clk);
        bus.i_wdata  = d;
        bus.i_wstrb  = s;
        bus.i_wvalid = 1'b1;
        @(negedge clk);
        bus.i_wvalid = 1'b0;
        checks++;
        if ({bus.o_wready, bus.o_awready, bus.o_bvalid} !== 3'b010)
            begin failures++; $display("FAIL w_first_held: wready/awready/bvalid=%b required 010",
                {bus.o_wready, bus.o_awready, bus.o_bvalid}); end
        @(negedge clk);
        @(negedge clk);
        bus.i_awaddr  = a;
        bus.i_awvalid = 1'b1;
        @(negedge clk);
        bus.i_awvalid = 1'b0;
        lat = 0;
        while (!bus.o_bvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 1 || bus.o_bresp !== 2'b00)
            begin failures++; $display("FAIL w_first_latency: cycles=%0d bresp=%b required 1/00", lat, bus.o_bresp); end
        @(negedge clk);
    endtask

    task automatic test_w_first();
        logic [31:0] d;
        logic [1:0]  r;
        write_w_first(32'h14, 32'hDEAD_BEEF, 4'hF);
        write_w_first(32'h14, 32'h0000_00AA, 4'h1);
        checks++;
        if (ctrl[63:32] !== 32'hDEAD_BEAA)
            begin failures++; $display("FAIL ctrl1_port: got %h required deadbeaa", ctrl[63:32]); end
        do_read(32'h14, d, r);
        checks++;
        if (d !== 32'hDEAD_BEAA)
            begin failures++; $display("FAIL ctrl1_readback: got %h required deadbeaa", d); end
    endtask

    task automatic test_slverr();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(32'h00, 32'h1234_5678, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin failures++; $display("FAIL version_write_bresp: got %b required 10", r); end
        do_write(32'h0C, 32'h1234_5678, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin failures++; $display("FAIL reserved_write_bresp: got %b required 10", r); end
        do_write(32'h20, 32'h1234_5678, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin failures++; $display("FAIL status_write_bresp: got %b required 10", r); end
        do_read(32'h00, d, r);
        checks++;
        if (d !== 32'h1010_0000) begin failures++; $display("FAIL version_unchanged: got %h required 10100000", d); end
        do_read(32'h40, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10)
            begin failures++; $display("FAIL invalid_read: got %h/%b required 0/10", d, r); end
        do_read(32'h28, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10)
            begin failures++; $display("FAIL past_status_read: got %h/%b required 0/10", d, r); end
        do_read(32'h20, d, r);
        checks++;
        if (d !== 32'hBEEF_0001 || r !== 2'b00)
            begin failures++; $display("FAIL status0_read: got %h/%b required beef0001/00", d, r); end
        do_read(32'h27, d, r);
        checks++;
        if (d !== 32'hCAFE_0002 || r !== 2'b00)
            begin failures++; $display("FAIL status1_read: got %h/%b required cafe0002/00", d, r); end
        do_write(32'h1C, 32'hFFFF_FFFF, 4'h0, r);
        checks++;
        if (r !== 2'b00 || ctrl[127:96] !== 32'h0)
            begin failures++; $display("FAIL zero_strobe: bresp=%b ctrl3=%h required 00/0", r, ctrl[127:96]); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(32'h08, 32'hFFFF_FF08, 4'hF, r);
        do_read(32'h08, d, r);
        checks++;
        if (d !== 32'h0000_0008 || r !== 2'b00)
            begin failures++; $display("FAIL irq_enable_read: got %h/%b required 00000008/00", d, r); end
        irq_src[3] = 1'b1;
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_early: got %b required 0", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_assert: got %b required 1", irq); end
        do_read(32'h04, d, r);
        checks++;
        if (d !== 32'h0000_0008) begin failures++; $display("FAIL irq_status_set: got %h required 8", d); end
        do_write(32'h04, 32'h0000_0008, 4'h1, r);
        checks++;
        if (irq !== 1'b0 || r !== 2'b00)
            begin failures++; $display("FAIL irq_w1c: irq=%b bresp=%b required 0/00", irq, r); end
        do_read(32'h04, d, r);
        checks++;
        if (d !== 32'h0 || irq !== 1'b0)
            begin failures++; $display("FAIL irq_level_no_reset: status=%h irq=%b required 0/0", d, irq); end
        // Re-arm bit 3, then land a new edge in the very cycle the W1C executes.
        irq_src[3] = 1'b0;
        @(negedge clk);
        irq_src[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        irq_src[3] = 1'b0;
        @(negedge clk);
        bus.i_awaddr  = 32'h04;
        bus.i_awvalid = 1'b1;
        bus.i_wdata   = 32'h08;
        bus.i_wstrb   = 4'h1;
        bus.i_wvalid  = 1'b1;
        @(negedge clk);
        bus.i_awvalid = 1'b0;
        bus.i_wvalid  = 1'b0;
        irq_src[3]    = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_bvalid !== 1'b1 || bus.o_bresp !== 2'b00)
            begin failures++; $display("FAIL set_wins_bvalid: got %b/%b required 1/00", bus.o_bvalid, bus.o_bresp); end
        @(negedge clk);
        do_read(32'h04, d, r);
        checks++;
        if (d !== 32'h0000_0008 || irq !== 1'b1)
            begin failures++; $display("FAIL set_wins: status=%h irq=%b required 8/1", d, irq); end
        irq_src[5] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        do_read(32'h04, d, r);
        checks++;
        if (d !== 32'h0000_0028) begin failures++; $display("FAIL irq_bit5: got %h required 28", d); end
        do_write(32'h04, 32'h0000_0028, 4'hF, r);
        do_read(32'h04, d, r);
        checks++;
        if (d !== 32'h0 || irq !== 1'b0)
            begin failures++; $display("FAIL irq_clear_all: status=%h irq=%b required 0/0", d, irq); end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        logic [1:0]  r;
        int          bad;
        bus.i_bready = 1'b0;
        bus.i_rready = 1'b0;
        @(negedge clk);
        bus.i_awaddr  = 32'h18;
        bus.i_wdata   = 32'h55AA_55AA;
        bus.i_wstrb   = 4'hF;
        bus.i_araddr  = 32'h18;
        bus.i_awvalid = 1'b1;
        bus.i_wvalid  = 1'b1;
        bus.i_arvalid = 1'b1;
        @(negedge clk);
        bus.i_awvalid = 1'b0;
        bus.i_wvalid  = 1'b0;
        bus.i_arvalid = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.o_bvalid !== 1'b1 || bus.o_bresp !== 2'b00 || bus.o_rvalid !== 1'b1 ||
                bus.o_rdata !== 32'h0 || bus.o_rresp !== 2'b00 ||
                {bus.o_awready, bus.o_wready, bus.o_arready} !== 3'b000)
                bad++;
        end
        checks++;
        if (bad !== 0)
            begin failures++; $display("FAIL stall_hold: %0d bad cycles required 0", bad); end
        bus.i_bready = 1'b1;
        bus.i_rready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.o_bvalid, bus.o_rvalid, bus.o_awready, bus.o_arready} !== 4'b0011)
            begin failures++; $display("FAIL stall_release: got %b required 0011",
                {bus.o_bvalid, bus.o_rvalid, bus.o_awready, bus.o_arready}); end
        do_read(32'h18, d, r);
        checks++;
        if (d !== 32'h55AA_55AA) begin failures++; $display("FAIL ctrl2_readback: got %h required 55aa55aa", d); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        logic [1:0]  r;
        int          seen;
        @(negedge clk);
        bus.i_awaddr  = 32'h10;
        bus.i_awvalid = 1'b1;
        @(negedge clk);
        bus.i_awvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ctrl !== 128'h0 || bus.o_awready !== 1'b0 || bus.o_bvalid !== 1'b0)
            begin failures++; $display("FAIL async_reset: ctrl=%h awready=%b bvalid=%b required 0",
                ctrl, bus.o_awready, bus.o_bvalid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.i_wdata  = 32'h0000_0077;
        bus.i_wstrb  = 4'hF;
        bus.i_wvalid = 1'b1;
        @(negedge clk);
        bus.i_wvalid = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.o_bvalid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL dropped_aw: bvalid seen %0d cycles required 0", seen); end
        bus.i_awaddr  = 32'h1C;
        bus.i_awvalid = 1'b1;
        @(negedge clk);
        bus.i_awvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_bvalid !== 1'b1) begin failures++; $display("FAIL post_reset_write: bvalid=%b required 1", bus.o_bvalid); end
        @(negedge clk);
        do_read(32'h10, d, r);
        checks++;
        if (d !== 32'h0 || ctrl[127:96] !== 32'h0000_0077)
            begin failures++; $display("FAIL post_reset_regs: ctrl0=%h ctrl3=%h required 0/77", d, ctrl[127:96]); end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        status        = {32'hCAFE_0002, 32'hBEEF_0001};
        irq_src       = '0;
        bus.i_awvalid = 1'b0;
        bus.i_awaddr  = '0;
        bus.i_wvalid  = 1'b0;
        bus.i_wdata   = '0;
        bus.i_wstrb   = '0;
        bus.i_bready  = 1'b1;
        bus.i_arvalid = 1'b0;
        bus.i_araddr  = '0;
        bus.i_rready  = 1'b1;

        test_reset();
        test_ctrl_write();
        test_w_first();
        test_slverr();
        test_irq();
        test_stall();
        test_reset_mid_write();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
